// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_pkg;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DEPTH_LOG2_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]              wptr_q, wptr_d;
  logic [PTR_W-1:0]              rptr_q, rptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q, mem_d;
  logic                          do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = ((wptr_q - rptr_q) == PTR_W'(DEPTH));
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[DEPTH_LOG2-1:0]] = din;
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a show-ahead byte FIFO for the core's UART read port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DEPTH_LOG2   = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              uart_rdreq,
  output logic              uart_empty,
  output logic [DATA_W-1:0] uart_in,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               sync1_q, sync1_d;
  logic               rxs_q, rxs_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               bit_end_c, half_end_c;
  logic               push_c, pop_c, full_c, empty_c;

  assign bit_end_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_end_c = (cnt_q == CNT_W'(HALF - 1));
  assign pop_c      = uart_rdreq & ~empty_c;
  assign uart_empty = empty_c;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Start is re-checked mid-bit so short line glitches fall back to IDLE silently.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs_q) state_d = START;
      START:   if (half_end_c) state_d = rxs_q ? IDLE : DATA;
      DATA:    if (bit_end_c && bit_q == BIT_W'(DATA_W - 1)) state_d = STOP;
      STOP:    if (bit_end_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync1_d     = rxd;
    rxs_d       = sync1_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = '0;
    end
    case (state_q)
      START: bit_d = '0;
      DATA: begin
        if (bit_end_c) begin
          shreg_d = {rxs_q, shreg_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          cnt_d   = '0;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          push_c      = rxs_q;
          frame_err_d = ~rxs_q;
        end
      end
      default: ;
    endcase
    overrun_d = overrun_q | (push_c & full_c & ~pop_c);
  end

  sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_c),
    .pop  (pop_c),
    .din  (shreg_q),
    .dout (uart_in),
    .full (full_c),
    .empty(empty_c)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int CPB     = 16;
  localparam int DL2     = 2;
  localparam int DEPTH   = 4;
  localparam int H       = CPB / 2;
  localparam int PUSH_K  = 2 + 1 + H + 9 * CPB;
  localparam int FRAME_K = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       uart_rdreq;
  logic       uart_empty;
  logic [7:0] uart_in;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_q[$];
  bit         overrun_m;
  int         first_ne_k;
  int         ferr_cnt;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .uart_rdreq(uart_rdreq),
    .uart_empty(uart_empty),
    .uart_in   (uart_in),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Effects of one clock edge on the model: pop first, then push.
  task automatic model_edge(input bit popped, input bit pushed, input logic [7:0] b);
    if (popped && model_q.size() > 0) void'(model_q.pop_front());
    if (pushed) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else overrun_m = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rxd = 1'b1; uart_rdreq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    overrun_m = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
      if (frame_err) ferr_cnt++;
    end
  endtask

  // Drives one full frame; pop_at < 0 means no pop request during the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    first_ne_k = -1;
    ferr_cnt   = 0;
    for (int k = 0; k < FRAME_K; k++) begin
      @(negedge clk);
      model_edge(uart_rdreq, (k == PUSH_K) && stop, b);
      if (frame_err) ferr_cnt++;
      if (!uart_empty && first_ne_k < 0) first_ne_k = k;
      rxd        = fr[k / CPB];
      uart_rdreq = (k == pop_at);
      if (uart_rdreq && model_q.size() > 0) check_eq("pop_in_frame", uart_in, model_q[0]);
    end
    @(negedge clk);
    model_edge(uart_rdreq, 1'b0, 8'h00);
    if (frame_err) ferr_cnt++;
    uart_rdreq = 1'b0;
    check_eq("frame_err_pulses", ferr_cnt, stop ? 0 : 1);
    check_eq("empty_after_frame", uart_empty, model_q.size() == 0);
    check_eq("overrun_after_frame", overrun, overrun_m);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rxd = 1'b1;
    check_eq("empty_before_pop", uart_empty, model_q.size() == 0);
    if (model_q.size() > 0) check_eq("pop_data", uart_in, model_q[0]);
    uart_rdreq = 1'b1;
    @(negedge clk);
    model_edge(1'b1, 1'b0, 8'h00);
    uart_rdreq = 1'b0;
  endtask

  task automatic drain();
    while (model_q.size() > 0) pop_one();
    @(negedge clk);
    check_eq("empty_after_drain", uart_empty, 1);
  endtask

  initial begin
    logic [9:0] fr;
    rst = 1'b1; rxd = 1'b1; uart_rdreq = 1'b0;
    overrun_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_empty", uart_empty, 1);
    check_eq("rst_uart_in", uart_in, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_frame_err", frame_err, 0);

    // Reset in the middle of a frame discards it.
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < FRAME_K / 2; k++) begin
      @(negedge clk);
      rxd = fr[k / CPB];
    end
    do_reset();
    ferr_cnt = 0;
    idle(200);
    check_eq("midrst_empty", uart_empty, 1);
    check_eq("midrst_overrun", overrun, 0);
    check_eq("midrst_uart_in", uart_in, 0);
    check_eq("midrst_frame_err", ferr_cnt, 0);

    // Single clean frame and its latency.
    send_frame(8'h5A, 1'b1, -1);
    check_eq("latency_window", (first_ne_k >= PUSH_K - 1) && (first_ne_k <= PUSH_K + 1), 1);
    pop_one();
    @(negedge clk);
    check_eq("empty_after_single_pop", uart_empty, 1);

    // Short glitch on the line: nothing received, receiver still usable.
    ferr_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    idle(200);
    check_eq("glitch_empty", uart_empty, 1);
    check_eq("glitch_frame_err", ferr_cnt, 0);
    send_frame(8'hC3, 1'b1, -1);
    drain();

    // Low stop bit.
    send_frame(8'h33, 1'b0, -1);
    idle(CPB);

    // Overflow without popping; overrun is sticky.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1);
    drain();
    pop_one();
    idle(20);
    check_eq("overrun_sticky", overrun, 1);
    check_eq("empty_after_extra_pop", uart_empty, 1);
    do_reset();
    @(negedge clk);
    check_eq("overrun_cleared", overrun, 0);

    // Pop coinciding with the push into a full FIFO.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
    send_frame(8'h05, 1'b1, PUSH_K - 1);
    check_eq("concurrent_no_overrun", overrun, 0);
    check_eq("concurrent_head", uart_in, 8'h02);
    drain();

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      int         pa;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      pa   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 150));
      send_frame(b, stop, pa);
      if ($urandom_range(0, 2) == 0) pop_one();
      idle(int'($urandom_range(0, 5)));
    end
    drain();
    check_eq("final_overrun", overrun, overrun_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end for the core's UART read port: 8N1 receiver plus a first-word-fall-through (show-ahead) byte FIFO.
- Sits directly upstream of the core's memory-mapped I/O, which it drives through uart_empty and uart_in; the core pops bytes with uart_rdreq.
- Converts the asynchronous rxd line into FIFO entries so the pipeline can stall-free poll for input.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rxd  in  1  asynchronous serial input, idle high
- uart_rdreq  in  1  pop request from core; ignored when uart_empty=1
- uart_empty  out  1  1 = no byte available
- uart_in  out  8  head-of-FIFO byte, valid whenever uart_empty=0
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky: byte dropped because FIFO full; cleared only by rst

Behaviour:
- Reset (rst high at a clk edge, honoured in every state and mid-frame):
  - synchronizer flops = 1; state = IDLE; bit counter and shift register = 0.
  - FIFO pointers = 0, so uart_empty = 1.
  - uart_in = 0, frame_err = 0, overrun = 0.
  - Any partial frame is discarded.
- Synchronizer: two flops on rxd; all decisions use the second flop (rxs).
- Let H = CLKS_PER_BIT/2 (integer floor). The cycle counter resets to 0 on every state entry.
- IDLE: when rxs == 0, go to START.
- START: count 0..H-1. At H-1, if rxs == 0 go to DATA (mid-start-bit confirmed); otherwise return to IDLE (glitch, no error).
- DATA:
  - Count 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 sample rxs into the shift register, LSB first, and restart the count.
  - After the 8th sample, go to STOP.
- STOP: count 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 sample rxs:
  - rxs == 1: push the byte into the FIFO, then go to IDLE.
  - rxs == 0: assert frame_err for 1 cycle, discard the byte, then go to IDLE. IDLE then waits for line high→low naturally, so a held-low break produces repeated framing errors, one per frame time.
- FIFO (depth 2^DEPTH_LOG2, pointers DEPTH_LOG2+1 bits wide, wrap naturally):
  - full = (wptr − rptr) == depth; empty = (wptr == rptr).
  - Push succeeds if not full, or if full and a valid pop occurs in the same cycle.
  - A push while full with no pop: byte dropped, overrun set to 1 (sticky).
  - Pop occurs when uart_rdreq & ~uart_empty. Pop on empty is ignored, with no pointer change.
  - A simultaneous push and pop on an empty FIFO is impossible, because the pop is gated by empty; the pushed byte appears next cycle.
  - uart_in = mem[rptr[DEPTH_LOG2-1:0]] (combinational read). The value is stale/don't-care while empty.
- Latency:
  - The push happens at the clk edge ending the STOP mid-sample cycle.
  - uart_empty falls on that same edge, i.e. visible in the next cycle.
  - From the first rxd low to push: 2 (sync) + 1 (IDLE detect) + H + 9·CLKS_PER_BIT cycles, ±1.
- Throughput: back-to-back frames are supported; at least 0.5 bit of margin remains after the stop sample.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - Default CLKS_PER_BIT constant.
  - Data width constant 8.
- One sub-module, sync_fifo: a parameterised show-ahead FIFO (push, pop, din, dout, full, empty) instantiated by uart_rx_fifo.
- The receiver FSM stays in the top module.

Test Plan (CLKS_PER_BIT=16, DEPTH_LOG2=2):
- Reset mid-frame: drive half of byte 0xA5, pulse rst → uart_empty=1, overrun=0, no byte later appears.
- Single frame 0x5A with correct stop → uart_empty falls about 2+1+8+144 cycles after the start edge; uart_in=0x5A; one rdreq → uart_empty=1.
- Glitch: rxd low for 4 cycles then high → no byte, no frame_err, FSM back in IDLE.
- Stop bit driven low on byte 0x33 → frame_err high exactly 1 cycle, FIFO stays empty.
- Send 0x01..0x05 without popping → first 4 stored, 5th dropped, overrun=1 and stays 1; pops return 0x01,0x02,0x03,0x04 in order, then empty. A further rdreq while empty → no change.
- FIFO full, rdreq asserted in the same cycle as a 5th byte push → no overrun; contents after drain 0x02..0x05.
